id_issue_stage: RTL and testbench
=================================

Name: id_issue_stage

Overview:
- Parametrised decode-to-execute issue stage; next generation of the decode pipeline register.
- Sits between fetch/decode and EXE. Inputs are the decoded instruction bundle from Decoder and raw register values from RegFile.
- Applies compare/operand forwarding, registers the bundle toward EXE, and handles stalls and forwarding freezes.
- Runs a configurable drain/notify sequence for serializing instructions (syscall, LL/SC).

Parameters:
- XLEN, 32, operand/PC/instruction data width.
- CTRL_W, 24, width of the opaque decoded-control bundle (ALU control, MemRead/MemWrite, RegWrite, dest reg, shamt).
- DRAIN_CYCLES, 3, bubbles issued after a serializing instruction before notify; legal range 1..15.

Ports:
- CLK  in  1  clock.
- RESET  in  1  asynchronous, active-high reset.
- in_valid  in  1  decode input holds a valid instruction.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction PC.
- in_ctrl  in  CTRL_W  decoded control bundle.
- in_serialize  in  1  instruction is serializing.
- in_notify  in  1  serializing instruction must raise sys (0 for LL/SC).
- in_raw_a, in_raw_b  in  XLEN  register-file values for rs and rt.
- fwd_sel_a, fwd_sel_b  in  2  forwarding select: 00 = raw, 01/11 = ALU, 10 = MEM.
- fwd_alu  in  XLEN  forwarded EXE result.
- fwd_mem  in  XLEN  forwarded MEM/WB data.
- fwd_req_freeze  in  1  forward logic requests a bubble.
- exe_stall  in  1  EXE cannot accept; hold outputs.
- flush  in  1  squash the output register and any serialize sequence.
- out_valid  out  1  registered bundle is valid.
- out_instr  out  32  registered instruction.
- out_pc  out  XLEN  registered PC.
- out_ctrl  out  CTRL_W  registered control bundle.
- out_opa, out_opb  out  XLEN  registered forwarded operands.
- want_freeze  out  1  combinational; fetch must hold PC/instruction.
- sys  out  1  registered one-cycle notify pulse.
- sys_pc  out  XLEN  PC of the serializing instruction, held until the next one.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, counter 0. Reset takes effect immediately and aborts any sequence mid-operation.
- Operand muxes (combinational):
  - opa = fwd_sel_a[0] ? fwd_alu : (fwd_sel_a==10 ? fwd_mem : in_raw_a).
  - opb is the same using fwd_sel_b and in_raw_b.
- States: IDLE, DRAIN, NOTIFY. Counter width is 4 bits.
- accept = IDLE & in_valid & !exe_stall & !fwd_req_freeze & !flush.
- Priority per edge: RESET > flush > exe_stall > fwd_req_freeze > state action.
- flush:
  - out_valid <= 0, out_ctrl <= 0, state <= IDLE, counter <= 0, sys <= 0.
  - sys_pc is kept.
- exe_stall (no flush):
  - All out_* hold.
  - FSM and counter hold.
  - sys <= 0.
- fwd_req_freeze in IDLE: out_valid <= 0 and out_ctrl <= 0 (bubble); input not consumed.
- IDLE with accept:
  - Register the bundle: out_valid=1, instr, pc, ctrl, opa, opb.
  - If in_serialize: latch notify <= in_notify, sys_pc <= in_pc, counter <= DRAIN_CYCLES, state <= DRAIN. The serializing instruction itself is issued this cycle so MEM can flush.
- IDLE, no accept: out_valid <= 0, out_ctrl <= 0.
- DRAIN:
  - Issues a bubble each cycle; input is ignored.
  - counter decrements; when counter==1 at the edge, state <= NOTIFY.
  - Exactly DRAIN_CYCLES bubbles are issued.
- NOTIFY: one bubble; sys <= notify for one cycle; state <= IDLE.
- sys is 0 in every cycle not entered from NOTIFY.
- want_freeze = exe_stall | fwd_req_freeze | (state != IDLE).
  - want_freeze is 0 in the IDLE cycle that accepts a serializing instruction, so fetch advances past it.
  - The next instruction is then held at the input until the state returns to IDLE.
- Back-to-back serializing instructions: the second is accepted on the first IDLE cycle after NOTIFY and starts a new sequence.
- busy = (state != IDLE).

Test Plan:
- Plain issue: reset, then in_valid=1, in_instr=0x00851020, in_pc=0x400100, raw_a=5, raw_b=7, sel=00 → next cycle out_valid=1, out_opa=5, out_opb=7, out_pc=0x400100, sys=0.
- Forwarding: fwd_sel_a=11, fwd_alu=0xDEAD, fwd_sel_b=10, fwd_mem=0xBEEF → out_opa=0xDEAD, out_opb=0xBEEF.
- Syscall, DRAIN_CYCLES=3, in_instr=0xC, in_notify=1, pc=0x400200:
  - Cycle 1: the syscall is issued.
  - Then 3 bubbles and 1 NOTIFY bubble; sys=1 for exactly one cycle; sys_pc=0x400200.
  - want_freeze=1 for 4 cycles.
  - The held next instruction issues on cycle 6.
- LL with in_notify=0: same timing as the syscall case; sys stays 0.
- exe_stall asserted for 2 cycles during DRAIN (counter=2) → outputs and counter frozen; sys fires 2 cycles later than nominal.
- flush in DRAIN, and separately RESET in NOTIFY → next cycle state IDLE, out_valid=0, sys=0, busy=0, want_freeze follows only the stall inputs.

Source files
------------

// File: rtl/id_issue_stage.sv
// Decode-to-execute issue register with operand forwarding, stall/freeze
// handling and a drain/notify sequence for serializing instructions.
module id_issue_stage #(
  parameter int XLEN         = 32,
  parameter int CTRL_W       = 24,
  parameter int DRAIN_CYCLES = 3   // 1..15
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              in_valid,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              in_serialize,
  input  logic              in_notify,
  input  logic [XLEN-1:0]   in_raw_a,
  input  logic [XLEN-1:0]   in_raw_b,
  input  logic [1:0]        fwd_sel_a,
  input  logic [1:0]        fwd_sel_b,
  input  logic [XLEN-1:0]   fwd_alu,
  input  logic [XLEN-1:0]   fwd_mem,
  input  logic              fwd_req_freeze,
  input  logic              exe_stall,
  input  logic              flush,
  output logic              out_valid,
  output logic [31:0]       out_instr,
  output logic [XLEN-1:0]   out_pc,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [XLEN-1:0]   out_opa,
  output logic [XLEN-1:0]   out_opb,
  output logic              want_freeze,
  output logic              sys,
  output logic [XLEN-1:0]   sys_pc,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, DRAIN, NOTIFY} state_e;

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                notify_q, notify_d;
  logic                out_valid_q, out_valid_d;
  logic [31:0]         out_instr_q, out_instr_d;
  logic [XLEN-1:0]     out_pc_q, out_pc_d;
  logic [CTRL_W-1:0]   out_ctrl_q, out_ctrl_d;
  logic [XLEN-1:0]     out_opa_q, out_opa_d;
  logic [XLEN-1:0]     out_opb_q, out_opb_d;
  logic                sys_q, sys_d;
  logic [XLEN-1:0]     sys_pc_q, sys_pc_d;
  logic [XLEN-1:0]     opa, opb;

  // Bit 0 selects the ALU result, so both 01 and 11 forward from EXE.
  assign opa = fwd_sel_a[0] ? fwd_alu : ((fwd_sel_a == 2'b10) ? fwd_mem : in_raw_a);
  assign opb = fwd_sel_b[0] ? fwd_alu : ((fwd_sel_b == 2'b10) ? fwd_mem : in_raw_b);

  always_comb begin
    // NOTE: every _d starts as a copy of its _q so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    notify_d    = notify_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    out_ctrl_d  = out_ctrl_q;
    out_opa_d   = out_opa_q;
    out_opb_d   = out_opb_q;
    sys_d       = 1'b0;
    sys_pc_d    = sys_pc_q;

    if (flush) begin
      out_valid_d = 1'b0;
      out_ctrl_d  = '0;
      state_d     = IDLE;
      cnt_d       = '0;
    end else if (exe_stall) begin
      // Hold everything; sys is a pulse and must not repeat.
    end else if (fwd_req_freeze) begin
      out_valid_d = 1'b0;
      out_ctrl_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            out_valid_d = 1'b1;
            out_instr_d = in_instr;
            out_pc_d    = in_pc;
            out_ctrl_d  = in_ctrl;
            out_opa_d   = opa;
            out_opb_d   = opb;
            if (in_serialize) begin
              notify_d = in_notify;
              sys_pc_d = in_pc;
              cnt_d    = DRAIN_INIT;
              state_d  = DRAIN;
            end
          end else begin
            out_valid_d = 1'b0;
            out_ctrl_d  = '0;
          end
        end
        DRAIN: begin
          out_valid_d = 1'b0;
          out_ctrl_d  = '0;
          cnt_d       = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = NOTIFY;
        end
        NOTIFY: begin
          out_valid_d = 1'b0;
          out_ctrl_d  = '0;
          sys_d       = notify_q;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      notify_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
      out_ctrl_q  <= '0;
      out_opa_q   <= '0;
      out_opb_q   <= '0;
      sys_q       <= 1'b0;
      sys_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      notify_q    <= notify_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
      out_ctrl_q  <= out_ctrl_d;
      out_opa_q   <= out_opa_d;
      out_opb_q   <= out_opb_d;
      sys_q       <= sys_d;
      sys_pc_q    <= sys_pc_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_instr   = out_instr_q;
  assign out_pc      = out_pc_q;
  assign out_ctrl    = out_ctrl_q;
  assign out_opa     = out_opa_q;
  assign out_opb     = out_opb_q;
  assign sys         = sys_q;
  assign sys_pc      = sys_pc_q;
  assign busy        = (state_q != IDLE);
  // Fetch keeps advancing in the IDLE cycle that accepts a serializer.
  assign want_freeze = exe_stall | fwd_req_freeze | (state_q != IDLE);

endmodule

// File: tb/tb_id_issue_stage.sv
// Directed bench for id_issue_stage: issue, forwarding, stall/freeze,
// serialize drain/notify timing, flush and reset aborts.
module tb_id_issue_stage;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 24;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              in_valid, in_serialize, in_notify;
  logic [31:0]       in_instr;
  logic [XLEN-1:0]   in_pc, in_raw_a, in_raw_b, fwd_alu, fwd_mem;
  logic [CTRL_W-1:0] in_ctrl;
  logic [1:0]        fwd_sel_a, fwd_sel_b;
  logic              fwd_req_freeze, exe_stall, flush;
  logic              out_valid, want_freeze, sys, busy;
  logic [31:0]       out_instr;
  logic [XLEN-1:0]   out_pc, out_opa, out_opb, sys_pc;
  logic [CTRL_W-1:0] out_ctrl;

  int vectors    = 0;
  int miscompares = 0;
  logic sys_seen;

  id_issue_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .DRAIN_CYCLES(3)) dut (
    .CLK(CLK), .RESET(RESET),
    .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_ctrl(in_ctrl),
    .in_serialize(in_serialize), .in_notify(in_notify),
    .in_raw_a(in_raw_a), .in_raw_b(in_raw_b),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .fwd_alu(fwd_alu), .fwd_mem(fwd_mem),
    .fwd_req_freeze(fwd_req_freeze), .exe_stall(exe_stall), .flush(flush),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_ctrl(out_ctrl), .out_opa(out_opa), .out_opb(out_opb),
    .want_freeze(want_freeze), .sys(sys), .sys_pc(sys_pc), .busy(busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET = 1'b1;
    in_valid = 0; in_serialize = 0; in_notify = 0;
    in_instr = '0; in_pc = '0; in_ctrl = '0; in_raw_a = '0; in_raw_b = '0;
    fwd_sel_a = 2'b00; fwd_sel_b = 2'b00; fwd_alu = '0; fwd_mem = '0;
    fwd_req_freeze = 0; exe_stall = 0; flush = 0;
    #12;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_sys", 32'(sys), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_freeze", 32'(want_freeze), 32'd0);
    check("rst_sys_pc", sys_pc, 32'd0);
    RESET = 1'b0;

    // Plain issue
    in_valid = 1; in_instr = 32'h00851020; in_pc = 32'h0040_0100;
    in_raw_a = 32'd5; in_raw_b = 32'd7; in_ctrl = 24'h00A5C3;
    tick();
    check("plain_valid", 32'(out_valid), 32'd1);
    check("plain_opa", out_opa, 32'd5);
    check("plain_opb", out_opb, 32'd7);
    check("plain_pc", out_pc, 32'h0040_0100);
    check("plain_instr", out_instr, 32'h00851020);
    check("plain_ctrl", 32'(out_ctrl), 32'h00A5C3);
    check("plain_sys", 32'(sys), 32'd0);

    // exe_stall holds the output register
    exe_stall = 1; in_instr = 32'h1111_1111; in_pc = 32'h0040_0104;
    #1 check("stall_freeze", 32'(want_freeze), 32'd1);
    tick();
    check("stall_valid", 32'(out_valid), 32'd1);
    check("stall_instr", out_instr, 32'h00851020);
    check("stall_pc", out_pc, 32'h0040_0100);
    exe_stall = 0;

    // Forwarding: 11 -> ALU, 10 -> MEM
    in_instr = 32'h00a62022; fwd_sel_a = 2'b11; fwd_alu = 32'hDEAD;
    fwd_sel_b = 2'b10; fwd_mem = 32'hBEEF; in_raw_a = 32'd1; in_raw_b = 32'd2;
    tick();
    check("fwd_opa_11", out_opa, 32'hDEAD);
    check("fwd_opb_10", out_opb, 32'hBEEF);
    // 01 -> ALU, 00 -> raw
    fwd_sel_a = 2'b01; fwd_alu = 32'h1234; fwd_sel_b = 2'b00; in_raw_b = 32'h77;
    tick();
    check("fwd_opa_01", out_opa, 32'h1234);
    check("fwd_opb_00", out_opb, 32'h77);
    fwd_sel_a = 2'b00;

    // Forward freeze inserts a bubble
    fwd_req_freeze = 1;
    #1 check("frz_want", 32'(want_freeze), 32'd1);
    tick();
    check("frz_valid", 32'(out_valid), 32'd0);
    check("frz_ctrl", 32'(out_ctrl), 32'd0);
    check("frz_busy", 32'(busy), 32'd0);
    fwd_req_freeze = 0;

    // Syscall: issue, 3 drain bubbles, notify bubble with sys, then next
    in_instr = 32'h0000000C; in_pc = 32'h0040_0200; in_serialize = 1; in_notify = 1;
    #1 check("sc_accept_freeze", 32'(want_freeze), 32'd0);
    tick();
    check("sc_issue_valid", 32'(out_valid), 32'd1);
    check("sc_issue_instr", out_instr, 32'h0000000C);
    check("sc_issue_busy", 32'(busy), 32'd1);
    check("sc_issue_freeze", 32'(want_freeze), 32'd1);
    check("sc_issue_sys", 32'(sys), 32'd0);
    in_serialize = 0; in_notify = 0; in_instr = 32'h8c880000; in_pc = 32'h0040_0204;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sc_drain_valid", 32'(out_valid), 32'd0);
      check("sc_drain_freeze", 32'(want_freeze), 32'd1);
      check("sc_drain_sys", 32'(sys), 32'd0);
    end
    tick();
    check("sc_notify_sys", 32'(sys), 32'd1);
    check("sc_notify_valid", 32'(out_valid), 32'd0);
    check("sc_sys_pc", sys_pc, 32'h0040_0200);
    check("sc_notify_busy", 32'(busy), 32'd0);
    check("sc_notify_freeze", 32'(want_freeze), 32'd0);
    tick();
    check("sc_next_valid", 32'(out_valid), 32'd1);
    check("sc_next_pc", out_pc, 32'h0040_0204);
    check("sc_next_sys", 32'(sys), 32'd0);

    // LL (no notify) followed back-to-back by a syscall
    in_instr = 32'hC0880000; in_pc = 32'h0040_0300; in_serialize = 1; in_notify = 0;
    tick();
    check("ll_issue_valid", 32'(out_valid), 32'd1);
    check("ll_issue_busy", 32'(busy), 32'd1);
    in_instr = 32'h0000000C; in_pc = 32'h0040_0304; in_notify = 1;
    sys_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      sys_seen |= sys;
      check("ll_bubble_valid", 32'(out_valid), 32'd0);
    end
    check("ll_no_sys", 32'(sys_seen), 32'd0);
    check("ll_sys_pc", sys_pc, 32'h0040_0300);
    check("ll_end_busy", 32'(busy), 32'd0);
    tick();
    check("b2b_issue_pc", out_pc, 32'h0040_0304);
    check("b2b_issue_busy", 32'(busy), 32'd1);
    in_valid = 0; in_serialize = 0; in_notify = 0;
    for (int i = 0; i < 3; i++) tick();
    tick();
    check("b2b_sys", 32'(sys), 32'd1);
    check("b2b_sys_pc", sys_pc, 32'h0040_0304);
    tick();
    check("b2b_sys_pulse", 32'(sys), 32'd0);

    // exe_stall for 2 cycles in DRAIN with counter at 2
    in_valid = 1; in_instr = 32'h0000000C; in_pc = 32'h0040_0400; in_serialize = 1; in_notify = 1;
    tick();
    in_serialize = 0; in_notify = 0; in_instr = 32'h20420001; in_pc = 32'h0040_0404;
    tick();
    exe_stall = 1;
    tick(); tick();
    check("dst_busy", 32'(busy), 32'd1);
    check("dst_freeze", 32'(want_freeze), 32'd1);
    check("dst_sys", 32'(sys), 32'd0);
    check("dst_pc_hold", out_pc, 32'h0040_0400);
    exe_stall = 0;
    tick();
    check("dst_nominal_sys", 32'(sys), 32'd0);
    tick();
    check("dst_late1_sys", 32'(sys), 32'd0);
    check("dst_late1_busy", 32'(busy), 32'd1);
    tick();
    check("dst_late_sys", 32'(sys), 32'd1);
    check("dst_sys_pc", sys_pc, 32'h0040_0400);
    tick();
    check("dst_next_valid", 32'(out_valid), 32'd1);
    check("dst_next_pc", out_pc, 32'h0040_0404);

    // flush in DRAIN
    in_instr = 32'h0000000C; in_pc = 32'h0040_0500; in_serialize = 1; in_notify = 1;
    tick();
    in_valid = 0; in_serialize = 0; in_notify = 0;
    tick();
    flush = 1;
    tick();
    check("fl_valid", 32'(out_valid), 32'd0);
    check("fl_ctrl", 32'(out_ctrl), 32'd0);
    check("fl_busy", 32'(busy), 32'd0);
    check("fl_sys", 32'(sys), 32'd0);
    check("fl_freeze", 32'(want_freeze), 32'd0);
    check("fl_sys_pc_kept", sys_pc, 32'h0040_0500);
    flush = 0;
    sys_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      sys_seen |= sys;
    end
    check("fl_no_sys", 32'(sys_seen), 32'd0);

    // RESET while in NOTIFY
    in_valid = 1; in_instr = 32'h0000000C; in_pc = 32'h0040_0600; in_serialize = 1; in_notify = 1;
    tick();
    in_valid = 0; in_serialize = 0; in_notify = 0;
    tick(); tick(); tick();
    check("rn_busy_before", 32'(busy), 32'd1);
    RESET = 1;
    #1;
    check("rn_busy", 32'(busy), 32'd0);
    check("rn_valid", 32'(out_valid), 32'd0);
    check("rn_sys", 32'(sys), 32'd0);
    check("rn_sys_pc", sys_pc, 32'd0);
    check("rn_freeze", 32'(want_freeze), 32'd0);
    tick();
    RESET = 0;
    tick();
    check("rn_after_sys", 32'(sys), 32'd0);
    check("rn_after_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
